irda_mir_rx_framer: RTL and testbench

//  MIR (1.152 Mb/s) receive framing controller. Sits after the MIR 4x-sample

---
 rtl/irda_mir_rx_framer.sv | 194 +++++++++++++++++++
 tb/tb_irda_mir_rx_framer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/irda_mir_rx_framer.sv
// MIR receive framer: flag hunt, zero-destuffing, LSB-first byte assembly with
// one-byte-late emission so the closing flag's leading bits never reach byte_o.
module irda_mir_rx_framer #(
  parameter int MAX_BYTES = 2050,
  parameter int CNT_W     = 12
) (
  input  logic       clk,
  input  logic       wb_rst_n,
  input  logic       fast_enable,
  input  logic       mir_mode,
  input  logic       tx_select,
  input  logic       dec_bit_i,
  input  logic       dec_vld_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       sof_o,
  output logic       eof_o,
  output logic       abort_o,
  output logic       frame_err_o,
  output logic       in_frame_o
);

  // state | meaning
  // HUNT  | waiting for an opening flag, data bits ignored
  // SYNC  | flag seen, assembling the first byte of a frame
  // DATA  | inside a frame, emitting the previous byte on each completion
  typedef enum logic [1:0] {HUNT, SYNC, DATA} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ones_q, ones_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_vld_q, byte_vld_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  logic             en;
  logic [2:0]       ones_inc;
  logic [7:0]       sh_new;
  logic [CNT_W:0]   cnt_inc;
  logic             over;
  logic             first;
  logic             is_flag;
  logic             is_data;

  assign en       = fast_enable & mir_mode & ~tx_select;
  assign ones_inc = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
  assign sh_new   = {dec_bit_i, shreg_q[7:1]};
  assign cnt_inc  = {1'b0, byte_cnt_q} + 1'b1;
  assign over     = 32'(cnt_inc) > 32'(MAX_BYTES);
  assign first    = (byte_cnt_q == '0);

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= HUNT;
      ones_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      byte_cnt_q <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      byte_cnt_q <= byte_cnt_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    byte_cnt_d = byte_cnt_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    abort_d    = 1'b0;
    err_d      = 1'b0;
    is_flag    = 1'b0;
    is_data    = 1'b0;

    if (!en) begin
      state_d    = HUNT;
      ones_d     = '0;
      bit_d      = '0;
      shreg_d    = '0;
      pend_d     = '0;
      pend_vld_d = 1'b0;
      byte_cnt_d = '0;
      byte_d     = '0;
    end else if (dec_vld_i) begin
      if (dec_bit_i) begin
        ones_d = ones_inc;
        if (ones_inc == 3'd7) begin
          abort_d    = (state_q == DATA);
          state_d    = HUNT;
          pend_vld_d = 1'b0;
          byte_cnt_d = '0;
        end else begin
          is_data = 1'b1;
        end
      end else begin
        ones_d = '0;
        if (ones_q == 3'd6)      is_flag = 1'b1;
        else if (ones_q != 3'd5) is_data = 1'b1;
      end

      if (is_flag) begin
        bit_d = '0;
        case (state_q)
          HUNT: state_d = SYNC;
          SYNC: err_d = (bit_q != 3'd7);
          default: begin
            state_d    = SYNC;
            pend_vld_d = 1'b0;
            byte_cnt_d = '0;
            if (bit_q != 3'd7) begin
              err_d = 1'b1;
            end else if (pend_vld_q) begin
              if (over) begin
                err_d   = 1'b1;
                state_d = HUNT;
              end else begin
                byte_d     = pend_q;
                byte_vld_d = 1'b1;
                sof_d      = first;
                eof_d      = 1'b1;
              end
            end
          end
        endcase
      end

      // Data bits are only assembled once a flag has given us byte alignment
      if (is_data && state_q != HUNT) begin
        shreg_d = sh_new;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          pend_d     = sh_new;
          pend_vld_d = 1'b1;
          if (state_q == SYNC) begin
            state_d    = DATA;
            byte_cnt_d = '0;
          end else if (over) begin
            err_d      = 1'b1;
            state_d    = HUNT;
            pend_vld_d = 1'b0;
            byte_cnt_d = '0;
          end else begin
            byte_d     = pend_q;
            byte_vld_d = 1'b1;
            sof_d      = first;
            byte_cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
      end
    end
  end

  assign byte_o      = byte_q;
  assign byte_vld_o  = byte_vld_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;
  assign abort_o     = abort_q;
  assign frame_err_o = err_q;
  assign in_frame_o  = (state_q == DATA);

endmodule

// File: tb/tb_irda_mir_rx_framer.sv
// Bench for irda_mir_rx_framer: HDLC encoder drives bits, expected output events
// are queued as frames are sent and compared when the DUT pulses.
module tb_irda_mir_rx_framer;

  logic       clk = 1'b0;
  logic       wb_rst_n, fast_enable, mir_mode, tx_select;
  logic       dec_bit, dec_vld, use_max;
  logic       vld_main, vld_max;
  logic [7:0] byte_o, m_byte;
  logic       byte_vld, sof, eof, abort_p, ferr, in_frame;
  logic       m_vld, m_sof, m_eof, m_abort, m_err, m_in_frame;

  int errors = 0;
  int checks = 0;
  int ones_run = 0;
  int gap = 1;
  int cyc = 0;
  int last_vld = -10;
  int mx_bytes = 0, mx_eof = 0, mx_err = 0;
  logic [12:0] exp_q[$];

  typedef struct {
    int          n;
    logic [31:0] data;
    int          gap;
    int          pre_flags;
  } vec_t;
  vec_t tbl[5];

  assign vld_main = dec_vld & ~use_max;
  assign vld_max  = dec_vld & use_max;

  irda_mir_rx_framer u_dut (
    .clk(clk), .wb_rst_n(wb_rst_n), .fast_enable(fast_enable), .mir_mode(mir_mode),
    .tx_select(tx_select), .dec_bit_i(dec_bit), .dec_vld_i(vld_main),
    .byte_o(byte_o), .byte_vld_o(byte_vld), .sof_o(sof), .eof_o(eof),
    .abort_o(abort_p), .frame_err_o(ferr), .in_frame_o(in_frame)
  );

  irda_mir_rx_framer #(.MAX_BYTES(4), .CNT_W(3)) u_max (
    .clk(clk), .wb_rst_n(wb_rst_n), .fast_enable(fast_enable), .mir_mode(mir_mode),
    .tx_select(tx_select), .dec_bit_i(dec_bit), .dec_vld_i(vld_max),
    .byte_o(m_byte), .byte_vld_o(m_vld), .sof_o(m_sof), .eof_o(m_eof),
    .abort_o(m_abort), .frame_err_o(m_err), .in_frame_o(m_in_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vld_main) last_vld <= cyc;
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // event word: {frame_err, abort, byte_vld, sof, eof, byte}
  always @(negedge clk) begin
    if (byte_vld || abort_p || ferr) begin
      logic [12:0] act;
      act = {ferr, abort_p, byte_vld, sof, eof, byte_vld ? byte_o : 8'h00};
      check("latency", cyc, last_vld + 1);
      if (exp_q.size() == 0) check("unexpected_event", {19'd0, act}, 32'd0);
      else check("event", {19'd0, act}, {19'd0, exp_q.pop_front()});
    end
    if (use_max) begin
      if (m_vld) mx_bytes++;
      if (m_vld && m_eof) mx_eof++;
      if (m_err) mx_err++;
    end
  end

  task automatic exp_byte(input logic [7:0] b, input logic s, input logic e);
    exp_q.push_back({2'b00, 1'b1, s, e, b});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    dec_bit = b;
    dec_vld = 1'b1;
    tick();
    dec_vld = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic send_data_bit(input logic b);
    send_bit(b);
    if (b) begin
      ones_run++;
      if (ones_run == 5) begin
        send_bit(1'b0);
        ones_run = 0;
      end
    end else begin
      ones_run = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_data_bit(b[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    ones_run = 0;
  endtask

  task automatic drain(input string name);
    repeat (6) tick();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{n: 2, data: 32'h0000_3CA5, gap: 1, pre_flags: 1};
    tbl[1] = '{n: 1, data: 32'h0000_00FF, gap: 1, pre_flags: 1};
    tbl[2] = '{n: 1, data: 32'h0000_0055, gap: 4, pre_flags: 3};
    tbl[3] = '{n: 3, data: 32'h0081_FF7E, gap: 2, pre_flags: 2};
    tbl[4] = '{n: 4, data: 32'hBEC3_8001, gap: 1, pre_flags: 1};

    wb_rst_n = 1'b0; fast_enable = 1'b1; mir_mode = 1'b1; tx_select = 1'b0;
    dec_bit = 1'b0; dec_vld = 1'b0; use_max = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {byte_o, byte_vld, sof, eof, abort_p, ferr, in_frame}, 32'd0);
    wb_rst_n = 1'b1;
    tick();
    check("idle_after_reset", {byte_vld, in_frame}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      gap = tbl[v].gap;
      ones_run = 0;
      for (int i = 0; i < tbl[v].n; i++)
        exp_byte(tbl[v].data[8*i +: 8], i == 0, i == tbl[v].n - 1);
      for (int k = 0; k < tbl[v].pre_flags; k++) send_flag();
      for (int i = 0; i < tbl[v].n; i++) send_byte(tbl[v].data[8*i +: 8]);
      send_flag();
      drain("frame_missing_events");
      check("in_frame_after_close", in_frame, 0);
    end
    check("byte_o_hold", byte_o, 8'hBE);
    gap = 1;

    // abort inside a frame, then recovery
    exp_q.push_back(13'b0_1_000_0000_0000);
    send_flag(); send_byte(8'h11);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    check("in_frame_after_abort", in_frame, 0);
    exp_byte(8'h22, 1'b1, 1'b1);
    ones_run = 0;
    send_flag(); send_byte(8'h22); send_flag();
    drain("abort_missing_events");

    // misaligned closing flag: byte boundary crosses inside the flag
    exp_byte(8'h01, 1'b1, 1'b0);
    exp_q.push_back(13'b1_0_000_0000_0000);
    send_flag(); send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_data_bit(1'b0);
    send_flag();
    check("in_frame_after_misalign", in_frame, 0);
    exp_byte(8'h33, 1'b1, 1'b1);
    send_flag(); send_byte(8'h33); send_flag();
    drain("misalign_missing_events");

    // tx_select for one cycle mid-frame
    send_flag(); send_byte(8'h11);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check("in_frame_before_tx", in_frame, 1);
    check("byte_o_before_tx", byte_o, 8'h33);
    tx_select = 1'b1; tick(); tx_select = 1'b0;
    check("tx_clears", {byte_o, byte_vld, in_frame}, 32'd0);
    exp_byte(8'h44, 1'b1, 1'b1);
    ones_run = 0;
    send_flag(); send_byte(8'h44); send_flag();
    drain("tx_missing_events");

    // reset mid-frame
    send_flag(); send_byte(8'h5A); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("in_frame_before_rst", in_frame, 1);
    wb_rst_n = 1'b0; tick();
    check("rst_clears", {byte_o, byte_vld, sof, eof, abort_p, ferr, in_frame}, 32'd0);
    wb_rst_n = 1'b1; tick();
    exp_byte(8'h66, 1'b1, 1'b1);
    ones_run = 0;
    send_flag(); send_byte(8'h66); send_flag();
    drain("rst_missing_events");

    // over-length frame on the MAX_BYTES=4 instance
    use_max = 1'b1;
    ones_run = 0;
    send_flag();
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
    send_flag();
    repeat (4) tick();
    check("max_bytes_out", mx_bytes, 4);
    check("max_frame_err", mx_err, 1);
    check("max_no_eof", mx_eof, 0);
    check("max_in_frame", m_in_frame, 0);
    use_max = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
